// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared types and constants for the sr_ff command generator.
//   state_e : one-hot FSM encoding (IDLE / DRIVE / CHECK)
//   cmd_e   : latched command (SET / CLR)
//   drive_t : registered s/r/en drive bundle
//   sat_inc : saturating increment for the optional statistics counters
package sr_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_DRIVE = 3'b010,
    ST_CHECK = 3'b100
  } state_e;

  typedef enum logic {
    CMD_SET = 1'b0,
    CMD_CLR = 1'b1
  } cmd_e;

  typedef struct packed {
    logic s;
    logic r;
    logic en;
  } drive_t;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int PULSE_CYCLES_DEF = 1;
  localparam int DEB_W_DEF        = 8;
  localparam int STAT_W           = 8;

  // Channel indices into the per-channel request vectors.
  localparam int CH_SET = 0;
  localparam int CH_CLR = 1;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: one request channel.
//   2-flop synchronizer -> debounce counter -> rising-edge pulse.
//   clk   : rising-edge clock
//   reset : async active-low reset
//   raw   : asynchronous, possibly bouncing request line
//   rise  : 1-cycle pulse when the debounced level goes 0 -> 1
// The debounced level follows the synced value only after it has
// disagreed for DEB_CYCLES consecutive edges; any agreement restarts.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1, sync2;
  logic             lvl, lvl_d;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

  // Only rising debounced edges produce events; falls are ignored.
  assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns raw set/clear requests into clean, exclusive s/r/en
// pulses for an sr_ff and verifies the returned q afterwards.
//   clk, reset        : clock / async active-low reset
//   set_req, clr_req  : raw async request lines (debounced internally)
//   q_fb              : q from the downstream sr_ff, checked in CHECK
//   err_clr           : synchronous clear of fb_err (set wins)
//   s, r, en          : registered drive outputs
//   busy              : high in DRIVE or CHECK
//   conflict          : 1-cycle pulse when both channels request in IDLE
//   fb_err            : sticky feedback mismatch flag
// Optional (macro SR_CMD_STATS_EN): set_cnt, clr_cnt, conf_cnt saturating
// statistics counters.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int DEB_W        = DEB_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  input  logic err_clr,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic conflict,
  output logic fb_err
`ifdef SR_CMD_STATS_EN
  ,
  output logic [STAT_W-1:0] set_cnt,
  output logic [STAT_W-1:0] clr_cnt,
  output logic [STAT_W-1:0] conf_cnt
`endif
);

  localparam int            PW        = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_CYCLES - 1);

  logic [1:0] raw, ev;
  assign raw = {clr_req, set_req};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    sr_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .DEB_W     (DEB_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[c]),
      .rise (ev[c])
    );
  end

  state_e        state, state_nxt;
  cmd_e          cmd, cmd_nxt;
  logic [1:0]    pend, pend_nxt, req;
  logic [PW-1:0] pcnt, pcnt_nxt;
  drive_t        drv, drv_nxt;
  logic          busy_nxt, conf_nxt;
  logic          chk_fail, enter_chk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cmd      <= CMD_SET;
      pend     <= '0;
      pcnt     <= '0;
      drv      <= '0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd      <= cmd_nxt;
      pend     <= pend_nxt;
      pcnt     <= pcnt_nxt;
      drv      <= drv_nxt;
      busy     <= busy_nxt;
      conflict <= conf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    pend_nxt  = pend;
    pcnt_nxt  = pcnt;
    conf_nxt  = 1'b0;
    req       = ev | pend;
    unique case (state)
      ST_IDLE: begin
        if (&req) begin
          // Simultaneous set and clear: drop both, including pendings.
          conf_nxt = 1'b1;
          pend_nxt = '0;
        end else if (req[CH_SET]) begin
          state_nxt        = ST_DRIVE;
          cmd_nxt          = CMD_SET;
          pend_nxt[CH_SET] = 1'b0;
          pcnt_nxt         = '0;
        end else if (req[CH_CLR]) begin
          state_nxt        = ST_DRIVE;
          cmd_nxt          = CMD_CLR;
          pend_nxt[CH_CLR] = 1'b0;
          pcnt_nxt         = '0;
        end
      end
      ST_DRIVE: begin
        pend_nxt = pend | ev;  // one-deep; repeats collapse
        if (pcnt == PCNT_LAST) state_nxt = ST_CHECK;
        else                   pcnt_nxt  = pcnt + PW'(1);
      end
      ST_CHECK: begin
        pend_nxt  = pend | ev;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    drv_nxt.en = (state_nxt == ST_DRIVE);
    drv_nxt.s  = drv_nxt.en & (cmd_nxt == CMD_SET);
    drv_nxt.r  = drv_nxt.en & (cmd_nxt == CMD_CLR);
    busy_nxt   = (state_nxt != ST_IDLE);
  end

  assign s  = drv.s;
  assign r  = drv.r;
  assign en = drv.en;

  assign chk_fail  = (state == ST_CHECK) & (q_fb != (cmd == CMD_SET));
  assign enter_chk = (state == ST_DRIVE) & (state_nxt == ST_CHECK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       fb_err <= 1'b0;
    else if (chk_fail) fb_err <= 1'b1;
    else if (err_clr)  fb_err <= 1'b0;
  end

`ifdef SR_CMD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_cnt  <= '0;
      clr_cnt  <= '0;
      conf_cnt <= '0;
    end else begin
      if (enter_chk && cmd == CMD_SET) set_cnt <= sat_inc(set_cnt);
      if (enter_chk && cmd == CMD_CLR) clr_cnt <= sat_inc(clr_cnt);
      if (conf_nxt)                    conf_cnt <= sat_inc(conf_cnt);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = enter_chk;
`endif

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
Upstream command stage for the sr_ff storage cell. It converts two raw, bouncy request lines (set, clear) into clean, mutually exclusive s/r/en drive pulses of programmable width. After each pulse it checks the flip-flop's q output for the expected state and flags conflicts and feedback errors.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples needed to accept a new request level (>=1)
PULSE_CYCLES, 1, cycles that en plus s or r are held high per command (>=1)
DEB_W, 8, width of the debounce counter (2**DEB_W > DEB_CYCLES)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
set_req  in  1  raw set request, asynchronous to clk, may bounce
clr_req  in  1  raw clear request, asynchronous to clk, may bounce
q_fb  in  1  q returned from the downstream sr_ff
err_clr  in  1  synchronous clear of fb_err
s  out  1  set drive to sr_ff
r  out  1  reset drive to sr_ff
en  out  1  enable drive to sr_ff
busy  out  1  high while in DRIVE or CHECK
conflict  out  1  one-cycle pulse: simultaneous set and clear dropped
fb_err  out  1  sticky: q_fb mismatched the expected value in CHECK

Behaviour:
- Reset (reset=0, async): all flops clear immediately. s=r=en=busy=conflict=fb_err=0, FSM=IDLE, pendings=0, debounced levels=0. A request still held high after reset releases is re-accepted after full latency.
- Sync: each raw input passes through 2 flops.
- Debounce: per channel. The debounced level takes the synced value at the edge where the synced value has differed from the debounced level for DEB_CYCLES consecutive edges. Any return to equality restarts the count. Falling debounced edges are ignored.
- Event: debounced rising edge, 1 cycle. An event arriving while busy sets the channel's pend flag (one deep). Further events on an already-pending channel are dropped.
- FSM: registered outputs, one-hot state internally.
  - IDLE: request = event OR pend per channel.
    - Both channels requesting: conflict=1 for 1 cycle, both pends cleared, stay IDLE.
    - Exactly one channel requesting: go to DRIVE with cmd latched and its pend cleared.
  - DRIVE: en=1. s=1 (cmd=SET) or r=1 (cmd=CLR). Lasts exactly PULSE_CYCLES cycles, then CHECK.
  - CHECK: en=s=r=0 for 1 cycle. Sample q_fb, expected 1 for SET and 0 for CLR. A mismatch sets fb_err. Then IDLE.
  - IDLE lasts at least 1 cycle between commands.
- Latency: raw high first sampled at edge 1 → s/r/en high after edge DEB_CYCLES+3. With DEB_CYCLES=4 this is edge 7.
- Invariants:
  - s&r is never 1.
  - s or r high implies en=1.
  - Outputs never change except in the FSM states listed above.
- fb_err: set has priority over an err_clr in the same cycle. err_clr clears fb_err at the next edge.

Optional Feature:
SR_CMD_STATS_EN
- Defined: adds outputs set_cnt[7:0], clr_cnt[7:0] and conf_cnt[7:0].
  - set_cnt and clr_cnt increment on entry to CHECK for their cmd.
  - conf_cnt increments on each conflict pulse.
  - All saturate at 255 and clear on reset.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Package sr_cmd_pkg holds:
  - state enum: ST_IDLE, ST_DRIVE, ST_CHECK
  - cmd enum: CMD_SET, CMD_CLR
  - default constants for DEB_CYCLES and PULSE_CYCLES
  - stats counter width (8)
- Sub-module sr_debounce: 2-flop sync, debounce counter and rising-edge pulse, parameterized by DEB_CYCLES and DEB_W. Instantiated twice.

Test Plan:
- Reset release, set_req held high 20 cycles, q_fb driven 1 during CHECK, defaults → s=en=1 for exactly 1 cycle after edge 7, r=0, busy high 2 cycles, fb_err=0, no second pulse.
- set_req toggles every 2 cycles for 12 cycles then stays 0 → s, en, busy never assert.
- set_req and clr_req rise on the same cycle, held → conflict=1 for exactly 1 cycle, s=r=en=0 throughout.
- clr_req command with q_fb held 1 → fb_err=1 after CHECK and stays 1 for 10 cycles; err_clr pulse → fb_err=0 next cycle.
- PULSE_CYCLES=3, set event followed by clr event during DRIVE → s high 3 cycles, CHECK, IDLE 1 cycle, then r high 3 cycles; no conflict.
- reset driven low mid-DRIVE → s and en drop without waiting for a clock edge, fb_err=0. With SR_CMD_STATS_EN defined, all counters read 0.
